ws2812_frame_scheduler: RTL
===========================

Name: ws2812_frame_scheduler

Overview:
- Owns a pixel framebuffer of NUM_LEDS 24-bit RGB entries.
- Sequences one complete WS2812 frame per start event into the downstream byte-serial WS2812 output shifter. Bytes go out in G, R, B order per LED, LED 0 first.
- A start event is a host pulse or the internal refresh timer. After the last byte, the block waits out the shifter's latch/reset tail before it accepts the next start.
- Sits between the host or pattern logic (write port) and the shifter (trigger/request/valid handshake).

Parameters:
- NUM_LEDS, 8: number of LEDs in the chain. Must be at least 1.
- INPUT_CLOCK, 12_000_000: clk frequency in Hz. Must match the shifter's setting.
- REFRESH_HZ, 100: auto-refresh frame rate. Period cycles = INPUT_CLOCK/REFRESH_HZ, integer division.
- GUARD_CYCLES, $rtoi(60e-6*INPUT_CLOCK)+2: idle cycles after end of frame before the next trigger is allowed. Covers the shifter's 60 us tailguard.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  framebuffer write strobe
- wr_addr  in  $clog2(NUM_LEDS) (min 1)  LED index. Writes with index >= NUM_LEDS are ignored.
- wr_data  in  24  {R[23:16], G[15:8], B[7:0]}
- frame_start  in  1  single-cycle request for one frame
- auto_en  in  1  enables the periodic refresh timer
- brightness  in  8  global scale (present only with the macro)
- sh_trigger  out  1  one-cycle start pulse to the shifter
- sh_data  out  8  byte to the shifter
- sh_data_valid  out  1  byte available
- sh_data_request  in  1  shifter is sampling sh_data/sh_data_valid this cycle
- busy  out  1  high from the accepted start until the guard expires
- frame_done  out  1  one-cycle pulse when the guard expires

Behaviour:
- Reset state: IDLE. sh_trigger=0, sh_data_valid=0, busy=0, frame_done=0. Refresh counter=0, led_idx=0, byte_sel=0. Framebuffer contents are not reset.
- Framebuffer: 1 write port and 1 synchronous read port (1-cycle latency). Writes are accepted in any state. A write to a LED not yet fetched in the current frame appears in that frame; a write to an already fetched LED appears in the next frame.
- Refresh timer: counts while auto_en=1 and the block is in IDLE. On reaching period-1 it generates a start event and clears. It is cleared whenever auto_en=0 or the block is not in IDLE.
- State machine:
  - IDLE: on frame_start or a timer event, go to FETCH. Set led_idx=0, byte_sel=0, busy=1. frame_start outside IDLE is ignored, not queued.
  - FETCH: issue a read of led_idx; next cycle latch the pixel register.
    - For the first pixel of the frame, assert sh_trigger for exactly one cycle, then go to STREAM.
    - For later pixels, go straight to STREAM.
  - STREAM: sh_data_valid=1 while bytes remain. sh_data = pixel G/R/B selected by byte_sel (0/1/2).
    - A byte is consumed when sh_data_request=1 and sh_data_valid=1. byte_sel then increments.
    - After byte_sel=2 is consumed: if led_idx<NUM_LEDS-1, increment led_idx and go to FETCH. Otherwise go to DRAIN.
    - Refetch latency of 2 cycles is below the shifter's minimum 8-bit serialisation time, so no request is ever missed.
  - DRAIN: sh_data_valid=0. The shifter's next request sees valid=0 and enters its tail. On that sh_data_request, load the guard counter with GUARD_CYCLES-1 and go to GUARD.
  - GUARD: count down to 0, then pulse frame_done for one cycle, clear busy, and return to IDLE.
- sh_data_valid is combinational from state, so it is ready in the same cycle the shifter samples it.
- sh_data_request while in IDLE or GUARD is ignored.
- Reset mid-frame: outputs return to their reset values on the next edge. The shifter shares rst.

Optional Feature:
- Macro: WS2812_SCHED_BRIGHTNESS_EN.
- Defined: brightness port exists. sh_data = (c*(brightness+1))>>8 per channel, using a 16-bit product and registered at the pixel latch. brightness=255 is identity; brightness=0 gives 0.
- Undefined: no brightness port; sh_data = raw channel byte.

Test Plan:
- NUM_LEDS=2; write LED0=0x112233, LED1=0xAABBCC; frame_start; shifter model requests bytes -> sh_data sequence 0x22,0x11,0x33,0xBB,0xAA,0xCC. Exactly one sh_trigger pulse. Then valid=0 on the 7th request.
- After the 7th request -> busy stays high for GUARD_CYCLES, then frame_done pulses once and busy=0 on the same edge.
- frame_start pulsed mid-STREAM -> ignored; exactly one frame is produced.
- auto_en=1, REFRESH_HZ tuned to a period of 1000 cycles -> back-to-back frames, each starting 1000 IDLE cycles after the previous frame_done. auto_en=0 -> no further triggers.
- rst asserted during the second LED -> next cycle sh_data_valid=0, busy=0, state IDLE. A subsequent frame_start streams from LED0.
- Macro defined, brightness=127, pixel 0xFF8040 -> bytes 0x40,0x7F,0x20. With brightness=255 -> bytes 0x80,0xFF,0x40.

Source files
------------

// File: rtl/ws2812_frame_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ws2812_frame_scheduler                                          |
// | Brief    : Framebuffer plus frame sequencer feeding a byte-serial WS2812   |
// |            shifter (G,R,B per LED, LED 0 first), with refresh timer and    |
// |            post-frame latch guard. Optional macro:                         |
// |            WS2812_SCHED_BRIGHTNESS_EN adds a global brightness scale.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module ws2812_frame_scheduler #(
    parameter int NUM_LEDS     = 8,
    parameter int INPUT_CLOCK  = 12_000_000,
    parameter int REFRESH_HZ   = 100,
    parameter int GUARD_CYCLES = $rtoi(60e-6 * INPUT_CLOCK) + 2
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                wr_en,
    input  logic [((NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1)-1:0] wr_addr,
    input  logic [23:0]                                         wr_data,
    input  logic                                                frame_start,
    input  logic                                                auto_en,
`ifdef WS2812_SCHED_BRIGHTNESS_EN
    input  logic [7:0]                                          brightness,
`endif
    output logic                                                sh_trigger,
    output logic [7:0]                                          sh_data,
    output logic                                                sh_data_valid,
    input  logic                                                sh_data_request,
    output logic                                                busy,
    output logic                                                frame_done
);

    localparam int              c_aw          = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [c_aw-1:0] c_last_led    = c_aw'(NUM_LEDS - 1);
    localparam logic [c_aw:0]   c_num_leds    = (c_aw + 1)'(NUM_LEDS);
    localparam logic [31:0]     c_period_last = 32'((INPUT_CLOCK / REFRESH_HZ) - 1);
    localparam logic [31:0]     c_guard_load  = 32'(GUARD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LATCH  = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4,
        S_GUARD  = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [23:0]     r_mem [NUM_LEDS];
    logic [23:0]     r_rd_data;
    logic [7:0]      r_pix_g;
    logic [7:0]      r_pix_r;
    logic [7:0]      r_pix_b;
    logic [c_aw-1:0] r_led_idx;
    logic [1:0]      r_byte_sel;
    logic [31:0]     r_refresh;
    logic [31:0]     r_guard;
    logic            r_busy;
    logic            r_done;
    logic            w_timer_hit;
    logic            w_start;
    logic            w_valid;
    logic            w_trigger;

    assign w_timer_hit = auto_en && (r_refresh == c_period_last);
    assign w_start     = (r_state == S_IDLE) && (frame_start || w_timer_hit);

`ifdef WS2812_SCHED_BRIGHTNESS_EN
    // (c * (brightness + 1)) >> 8 keeps 255 as identity and 0 as black
    function automatic logic [7:0] f_scale(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, b} + 16'd1);
        return prod[15:8];
    endfunction
`endif

    // Read is issued every cycle; the value captured at the end of FETCH is the pixel
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < c_num_leds)) begin
            r_mem[wr_addr] <= wr_data;
        end
        r_rd_data <= r_mem[r_led_idx];
    end

    always_ff @(posedge clk) begin
        if (r_state == S_LATCH) begin
`ifdef WS2812_SCHED_BRIGHTNESS_EN
            r_pix_r <= f_scale(r_rd_data[23:16], brightness);
            r_pix_g <= f_scale(r_rd_data[15:8],  brightness);
            r_pix_b <= f_scale(r_rd_data[7:0],   brightness);
`else
            r_pix_r <= r_rd_data[23:16];
            r_pix_g <= r_rd_data[15:8];
            r_pix_b <= r_rd_data[7:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_valid      = 1'b0;
        w_trigger    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                w_next_state = S_LATCH;
            end
            S_LATCH: begin
                w_trigger    = (r_led_idx == '0);
                w_next_state = S_STREAM;
            end
            S_STREAM: begin
                w_valid = 1'b1;
                if (sh_data_request && (r_byte_sel == 2'd2)) begin
                    w_next_state = (r_led_idx == c_last_led) ? S_DRAIN : S_FETCH;
                end
            end
            S_DRAIN: begin
                if (sh_data_request) begin
                    w_next_state = S_GUARD;
                end
            end
            S_GUARD: begin
                if (r_guard == '0) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led_idx  <= '0;
            r_byte_sel <= '0;
            r_refresh  <= '0;
            r_guard    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Timer only runs while idle and enabled; a hit restarts it from zero
            if ((r_state == S_IDLE) && auto_en && !w_timer_hit) begin
                r_refresh <= r_refresh + 32'd1;
            end else begin
                r_refresh <= '0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_led_idx  <= '0;
                        r_byte_sel <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                S_STREAM: begin
                    if (sh_data_request) begin
                        if (r_byte_sel == 2'd2) begin
                            r_byte_sel <= '0;
                            if (r_led_idx != c_last_led) begin
                                r_led_idx <= r_led_idx + 1'b1;
                            end
                        end else begin
                            r_byte_sel <= r_byte_sel + 2'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (sh_data_request) begin
                        r_guard <= c_guard_load;
                    end
                end
                S_GUARD: begin
                    if (r_guard == '0) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_guard <= r_guard - 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        case (r_byte_sel)
            2'd0:    sh_data = r_pix_g;
            2'd1:    sh_data = r_pix_r;
            default: sh_data = r_pix_b;
        endcase
    end

    assign sh_trigger    = w_trigger;
    assign sh_data_valid = w_valid;
    assign busy          = r_busy;
    assign frame_done    = r_done;

endmodule
`default_nettype wire
